// File: rtl/eth_tx_framer.sv
// eth_tx_framer: pops payload from a FWFT byte FIFO and emits preamble, SFD, payload, pad, FCS, IFG on GMII.
// Define ETH_TX_FCS_EN to build the CRC-32 generator and append the 4-byte FCS.
module eth_tx_framer #(
   parameter int LEN_WIDTH      = 11,
   parameter int MIN_PAYLOAD    = 60,
   parameter int PREAMBLE_BYTES = 7,
   parameter int IFG_BYTES      = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_tx_start,
   input  logic [LEN_WIDTH-1:0] i_tx_len,
   output logic                 o_tx_busy,
   output logic                 o_tx_done,
   output logic                 o_tx_underrun,
   output logic                 o_fifo_rd_en,
   input  logic [7:0]           i_fifo_dout,
   input  logic                 i_fifo_empty,
   output logic [7:0]           o_gmii_txd,
   output logic                 o_gmii_tx_en,
   output logic                 o_gmii_tx_er
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_IFG
`ifdef ETH_TX_FCS_EN
      , S_FCS
`endif
   } state_t;

`ifdef ETH_TX_FCS_EN
   localparam state_t S_POST = S_FCS;
`else
   localparam state_t S_POST = S_IFG;
`endif

   localparam logic [LEN_WIDTH-1:0] C_PRE_LAST = LEN_WIDTH'(PREAMBLE_BYTES - 1);
   localparam logic [LEN_WIDTH-1:0] C_MIN      = LEN_WIDTH'(MIN_PAYLOAD);
   localparam logic [LEN_WIDTH-1:0] C_MIN_LAST = LEN_WIDTH'(MIN_PAYLOAD - 1);
   localparam logic [LEN_WIDTH-1:0] C_IFG_LAST = LEN_WIDTH'(IFG_BYTES - 1);

   state_t                r_state, w_next;
   logic [LEN_WIDTH-1:0]  r_cnt, r_len;
   logic [LEN_WIDTH-1:0]  w_len_last;
   logic                  r_abort;
   logic                  w_pop;
   logic [7:0]            w_txd;
   logic                  w_en, w_er, w_und, w_done;

   assign w_pop        = (r_state == S_PAYLOAD) && !i_fifo_empty;
   assign o_fifo_rd_en = w_pop;
   assign o_tx_busy    = (r_state != S_IDLE);
   assign w_len_last   = r_len - LEN_WIDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (i_tx_start && (i_tx_len != '0)) w_next = S_PREAMBLE;
         S_PREAMBLE: if (r_cnt == C_PRE_LAST) w_next = S_SFD;
         S_SFD:      w_next = S_PAYLOAD;
         S_PAYLOAD: begin
            if (i_fifo_empty)              w_next = S_IFG;
            else if (r_cnt == w_len_last)  w_next = (r_len < C_MIN) ? S_PAD : S_POST;
         end
         S_PAD:      if (r_cnt == C_MIN_LAST) w_next = S_POST;
`ifdef ETH_TX_FCS_EN
         S_FCS:      if (r_cnt == LEN_WIDTH'(3)) w_next = S_IFG;
`endif
         S_IFG:      if (r_cnt == C_IFG_LAST) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // r_cnt restarts per state, except PAYLOAD->PAD keeps counting toward MIN_PAYLOAD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_len   <= '0;
         r_abort <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (w_next == S_PREAMBLE) begin
               r_len   <= i_tx_len;
               r_abort <= 1'b0;
            end
         end else if ((w_next != r_state) && (w_next != S_PAD)) begin
            r_cnt <= '0;
         end else if ((r_state != S_PAYLOAD) || w_pop) begin
            r_cnt <= r_cnt + LEN_WIDTH'(1);
         end
         if ((r_state == S_PAYLOAD) && i_fifo_empty) r_abort <= 1'b1;
      end
   end

`ifdef ETH_TX_FCS_EN
   logic [31:0] r_crc, w_crc_next, w_fcs;
   logic [7:0]  w_fcs_byte;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      return x;
   endfunction

   assign w_crc_next = crc32_byte(r_crc, (r_state == S_PAD) ? 8'h00 : i_fifo_dout);
   assign w_fcs      = ~r_crc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           r_crc <= 32'hFFFF_FFFF;
      else if (r_state == S_IDLE)           r_crc <= 32'hFFFF_FFFF;
      else if (w_pop || (r_state == S_PAD)) r_crc <= w_crc_next;
   end

   always_comb begin
      w_fcs_byte = w_fcs[7:0];
      case (r_cnt[1:0])
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         2'd3:    w_fcs_byte = w_fcs[31:24];
         default: w_fcs_byte = w_fcs[7:0];
      endcase
   end
`endif

   always_comb begin
      w_txd  = 8'h00;
      w_en   = 1'b0;
      w_er   = 1'b0;
      w_und  = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_PREAMBLE: begin w_txd = 8'h55; w_en = 1'b1; end
         S_SFD:      begin w_txd = 8'hD5; w_en = 1'b1; end
         S_PAYLOAD: begin
            w_en = 1'b1;
            if (i_fifo_empty) begin
               w_er  = 1'b1;
               w_und = 1'b1;
            end else begin
               w_txd = i_fifo_dout;
            end
         end
         S_PAD:      w_en = 1'b1;
`ifdef ETH_TX_FCS_EN
         S_FCS:      begin w_txd = w_fcs_byte; w_en = 1'b1; end
`endif
         S_IFG:      w_done = (w_next == S_IDLE) && !r_abort;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_gmii_txd    <= 8'h00;
         o_gmii_tx_en  <= 1'b0;
         o_gmii_tx_er  <= 1'b0;
         o_tx_underrun <= 1'b0;
         o_tx_done     <= 1'b0;
      end else begin
         o_gmii_txd    <= w_txd;
         o_gmii_tx_en  <= w_en;
         o_gmii_tx_er  <= w_er;
         o_tx_underrun <= w_und;
         o_tx_done     <= w_done;
      end
   end

endmodule

// File: doc/eth_tx_framer.md
Name: eth_tx_framer

Overview:
- Downstream consumer of the transmit byte FIFO (first-word-fall-through: dout valid whenever !empty).
- On a start command, pops exactly tx_len payload bytes and emits a GMII-style byte stream: preamble, SFD, payload, zero padding to minimum size, optional FCS, then inter-frame gap.
- Sits between the packet builder/FIFO and the MAC/PHY byte interface.

Parameters:
LEN_WIDTH, 11, width of tx_len (max 2047 bytes)
MIN_PAYLOAD, 60, minimum bytes before FCS; shorter frames are zero-padded
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD
IFG_BYTES, 12, idle cycles after frame before next start accepted

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
tx_start  in  1  start request; sampled only in IDLE
tx_len  in  LEN_WIDTH  payload byte count, sampled with tx_start
tx_busy  out  1  high whenever state != IDLE
tx_done  out  1  one-cycle pulse on return to IDLE after normal frame
tx_underrun  out  1  one-cycle pulse when FIFO empty during PAYLOAD
fifo_rd_en  out  1  pop strobe to FIFO
fifo_dout  in  8  FIFO head byte
fifo_empty  in  1  FIFO empty flag
gmii_txd  out  8  transmit byte, registered
gmii_tx_en  out  1  frame valid, registered
gmii_tx_er  out  1  error marker, registered

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE, counters 0, CRC 0xFFFFFFFF; gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, tx_busy=0, tx_done=0, tx_underrun=0, fifo_rd_en=0. Aborted frame is not resumed.
- States: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
- IDLE: tx_start=1 and tx_len!=0 at edge N -> latch len, go PREAMBLE. tx_len=0 ignored (stays IDLE, no pulses). tx_start outside IDLE ignored.
- Output timing: cycle N+1..N+7 txd=0x55, tx_en=1; N+8 txd=0xD5; payload byte i appears at N+9+i.
- PAYLOAD: fifo_rd_en = (state==PAYLOAD) && !fifo_empty, combinational; popped byte registered onto gmii_txd next cycle. One byte per cycle, no gaps. Byte counter counts pops; after tx_len pops -> PAD if tx_len<MIN_PAYLOAD, else FCS.
- Underrun: fifo_empty while PAYLOAD needs a byte -> next cycle gmii_tx_en=1, gmii_tx_er=1, txd=0x00 for one cycle, tx_underrun pulses same cycle, go IFG; no FCS; tx_done not pulsed. Unread bytes of that frame remain in FIFO (upstream flushes).
- PAD: emits 0x00 for MIN_PAYLOAD-tx_len cycles; padding included in CRC.
- FCS: CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, over payload+pad, complemented, 4 bytes LSB byte first. Byte-wise combinational CRC update, registered per byte.
- IFG: gmii_tx_en=0, txd=0x00 for IFG_BYTES cycles; then IDLE with tx_done=1 for that one cycle (normal frames only).
- tx_en deasserts exactly one cycle after last FCS byte. Frame length on wire = PREAMBLE_BYTES+1+max(tx_len,MIN_PAYLOAD)+4.
- Counters sized for LEN_WIDTH; no wrap inside a frame.

Optional Feature:
- Macro ETH_TX_FCS_EN. Defined: FCS state present as above. Undefined: CRC logic not built, FCS state skipped, PAD/PAYLOAD go directly to IFG; wire length = PREAMBLE_BYTES+1+max(tx_len,MIN_PAYLOAD). All other timing unchanged.

Test Plan:
- FIFO preloaded 64 bytes 0x00..0x3F, tx_len=64 -> 7x0x55, 0xD5, 0x00..0x3F, 4 FCS bytes; running CRC (no final complement) over payload+FCS = 0xDEBB20E3; tx_en high 76 cycles; tx_done 12 cycles later.
- tx_len=10, bytes 0xA0..0xA9 -> 10 payload, 50x0x00 pad, FCS over 60 bytes matches model; exactly 10 pops.
- tx_len=20, only 5 bytes in FIFO -> 5 payload bytes then one cycle tx_er=1, tx_underrun pulse, no FCS, 12 IFG, no tx_done.
- Back-to-back: tx_start held high continuously -> second frame preamble begins exactly 1 cycle after tx_done cycle; gap of tx_en=0 = 13 cycles.
- rst_n low mid-PAYLOAD -> tx_en/tx_er/fifo_rd_en 0 immediately (async), tx_busy 0; new tx_start after release starts fresh preamble.
- tx_len=0 with tx_start -> no output, no pops, tx_busy stays 0.
